reg_bank_bus_ctrl: RTL and testbench

- Parametrised register bank with a shared-bus interface for the down-sampling processor datapath.
- Supersedes the two-register combinational read mux with NUM_REGS registers of DATA_W bits.
- Adds synchronous write-from-bus, increment and clear micro-ops, a registered read with a valid strobe, and an address-error flag.
- Sits between the control unit (which issues the ops) and the shared data bus; all register contents are also exported flat to the ALU.

---
 rtl/reg_bank_bus_ctrl.sv | 86 ++++++++
 tb/tb_reg_bank_bus_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_bus_ctrl.sv
// Register bank for the down-sampling datapath: clr/write/inc micro-ops on the
// addressed register, a registered read onto the shared bus, and an address-error pulse.
module reg_bank_bus_ctrl #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [ADDR_W-1:0]          reg_addr,
   input  logic                       read,
   input  logic                       write,
   input  logic                       inc,
   input  logic                       clr,
   input  logic [DATA_W-1:0]          bus_in,
   output logic [DATA_W-1:0]          bus_out,
   output logic                       rd_valid,
   output logic                       rd_zero,
   output logic                       addr_err,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] rd_data;
   logic              addr_ok;
   logic              any_op;
   logic              rd_ok;

   // A fully populated address space can never be out of range.
   generate
      if (NUM_REGS == (1 << ADDR_W)) begin : g_full
         assign addr_ok = 1'b1;
      end else begin : g_partial
         localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);
         assign addr_ok = ({1'b0, reg_addr} < NUM_REGS_L);
      end
   endgenerate

   assign any_op = read | write | inc | clr;
   assign rd_ok  = read & addr_ok;

   always_comb begin
      // NOTE: default assigned first so an unmatched address cannot infer a latch.
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (reg_addr == ADDR_W'(i)) rd_data = regs_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the bank is built from flops, not RAM, so every word is reset.
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_addr == ADDR_W'(i)) begin
               // NOTE: non-blocking so the read path sees the pre-edge value.
               if (clr)        regs_q[i] <= '0;
               else if (write) regs_q[i] <= bus_in;
               else if (inc)   regs_q[i] <= regs_q[i] + DATA_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_out  <= '0;
         rd_valid <= 1'b0;
         rd_zero  <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         bus_out  <= rd_ok ? rd_data : '0;
         rd_valid <= rd_ok;
         rd_zero  <= rd_ok && (rd_data == '0);
         addr_err <= any_op && !addr_ok;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
         assign regs_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
      end
   endgenerate

endmodule

// File: tb/tb_reg_bank_bus_ctrl.sv
// Scoreboard bench for reg_bank_bus_ctrl: a 4-register instance for data paths
// and a 3-register instance for the out-of-range address flag.
module tb_reg_bank_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [1:0]  reg_addr;
   logic        read, write, inc, clr;
   logic [7:0]  bus_in;
   logic [7:0]  bus_out;
   logic        rd_valid, rd_zero, addr_err;
   logic [31:0] regs_flat;

   logic [1:0]  e_addr;
   logic        e_read, e_write, e_inc, e_clr;
   logic [7:0]  e_bus_in;
   logic [7:0]  e_bus_out;
   logic        e_rd_valid, e_rd_zero, e_addr_err;
   logic [23:0] e_regs_flat;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  sb [$];

   always #5 clk = ~clk;

   reg_bank_bus_ctrl #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .read(read), .write(write),
      .inc(inc), .clr(clr), .bus_in(bus_in), .bus_out(bus_out), .rd_valid(rd_valid),
      .rd_zero(rd_zero), .addr_err(addr_err), .regs_flat(regs_flat)
   );

   reg_bank_bus_ctrl #(.DATA_W(8), .NUM_REGS(3), .ADDR_W(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .reg_addr(e_addr), .read(e_read), .write(e_write),
      .inc(e_inc), .clr(e_clr), .bus_in(e_bus_in), .bus_out(e_bus_out),
      .rd_valid(e_rd_valid), .rd_zero(e_rd_zero), .addr_err(e_addr_err),
      .regs_flat(e_regs_flat)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every read result is popped and compared; idle cycles must show a quiet bus.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
            end else begin
               logic [7:0] exp;
               exp = sb.pop_front();
               check("bus_out", 32'(bus_out), 32'(exp));
               check("rd_zero", 32'(rd_zero), 32'(exp == 8'h00));
            end
         end else begin
            check("idle_bus_out", 32'(bus_out), 32'd0);
            check("idle_rd_zero", 32'(rd_zero), 32'd0);
         end
      end
   end

   task automatic op(input logic [1:0] a, input logic r, input logic w, input logic i,
                     input logic c, input logic [7:0] d, input logic [7:0] exp_rd);
      reg_addr = a; read = r; write = w; inc = i; clr = c; bus_in = d;
      if (r) sb.push_back(exp_rd);
      @(posedge clk); #1;
      if (r) check("rd_valid_after_read", 32'(rd_valid), 32'd1);
   endtask

   task automatic idle();
      read = 1'b0; write = 1'b0; inc = 1'b0; clr = 1'b0;
      e_read = 1'b0; e_write = 1'b0; e_inc = 1'b0; e_clr = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic e_op(input logic [1:0] a, input logic r, input logic w, input logic [7:0] d);
      e_addr = a; e_read = r; e_write = w; e_inc = 1'b0; e_clr = 1'b0; e_bus_in = d;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1;
      reg_addr = '0; read = 1'b0; write = 1'b0; inc = 1'b0; clr = 1'b0; bus_in = '0;
      e_addr = '0; e_read = 1'b0; e_write = 1'b0; e_inc = 1'b0; e_clr = 1'b0; e_bus_in = '0;

      // Reset asserted before the first clock edge must take effect immediately.
      #2 rst_n = 1'b0;
      #1;
      check("reset_regs_flat", regs_flat, 32'h0);
      check("reset_rd_valid", 32'(rd_valid), 32'd0);
      check("reset_addr_err", 32'(addr_err), 32'd0);
      check("reset_e_regs_flat", 32'(e_regs_flat), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Write then back-to-back read of all four registers.
      op(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h00);
      op(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 8'h00);
      op(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 8'h00);
      op(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 8'h00);
      op(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11);
      op(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h22);
      op(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h33);
      op(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h44);
      idle();
      check("flat_after_writes", regs_flat, 32'h44332211);
      check("rd_valid_drops_when_idle", 32'(rd_valid), 32'd0);

      // Increment wraps from all-ones to zero.
      op(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFE, 8'h00);
      op(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      check("inc_to_ff", 32'(regs_flat[23:16]), 32'hFF);
      op(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      check("inc_wrap", 32'(regs_flat[23:16]), 32'h00);
      op(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      idle();

      // Priority clr > write > inc.
      op(2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 8'h00);
      check("clr_wins", 32'(regs_flat[15:8]), 32'h00);
      op(2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 8'h00);
      check("write_beats_inc", 32'(regs_flat[15:8]), 32'h5A);
      check("others_hold", regs_flat, 32'h44005A11);

      // Read-before-write on the same register.
      op(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h99, 8'h44);
      op(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99);
      idle();
      check("flat_after_rbw", regs_flat, 32'h99005A11);
      check("full_space_no_addr_err", 32'(addr_err), 32'd0);

      // Out-of-range address on the 3-register instance.
      e_op(2'd0, 1'b0, 1'b1, 8'h10);
      e_op(2'd1, 1'b0, 1'b1, 8'h20);
      e_op(2'd2, 1'b0, 1'b1, 8'h30);
      e_op(2'd3, 1'b0, 1'b1, 8'h77);
      check("oor_write_addr_err", 32'(e_addr_err), 32'd1);
      check("oor_write_no_change", 32'(e_regs_flat), 32'h302010);
      idle();
      check("addr_err_one_cycle", 32'(e_addr_err), 32'd0);
      e_op(2'd3, 1'b1, 1'b0, 8'h00);
      check("oor_read_addr_err", 32'(e_addr_err), 32'd1);
      check("oor_read_rd_valid", 32'(e_rd_valid), 32'd0);
      check("oor_read_bus_out", 32'(e_bus_out), 32'd0);
      e_op(2'd2, 1'b1, 1'b0, 8'h00);
      check("inrange_clears_addr_err", 32'(e_addr_err), 32'd0);
      check("inrange_rd_valid", 32'(e_rd_valid), 32'd1);
      check("inrange_bus_out", 32'(e_bus_out), 32'h30);
      check("inrange_rd_zero", 32'(e_rd_zero), 32'd0);
      idle();

      // Asynchronous reset between edges while a read is in progress.
      reg_addr = 2'd0; read = 1'b1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_regs_flat", regs_flat, 32'h0);
      check("async_rst_bus_out", 32'(bus_out), 32'd0);
      check("async_rst_rd_valid", 32'(rd_valid), 32'd0);
      check("async_rst_rd_zero", 32'(rd_zero), 32'd0);
      check("async_rst_e_regs_flat", 32'(e_regs_flat), 32'h0);
      repeat (2) begin
         @(posedge clk); #1;
         check("rst_hold_regs_flat", regs_flat, 32'h0);
         check("rst_hold_rd_valid", 32'(rd_valid), 32'd0);
      end
      @(negedge clk) rst_n = 1'b1;
      op(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      idle();
      repeat (2) idle();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
